// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared definitions for the HI/LO divide controller: the FSM state
// encoding and the constant written to LO on a divide by zero.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // LO value for a zero divisor (all ones quotient)
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl
// Sequences a DIV/DIVU from the E stage through an external multi-cycle
// divider and writes the {remainder, quotient} result into HI/LO.
// Stalls the front of the pipeline while the divide is in flight, aborts
// on E-stage flush or on a divider that never answers (sticky err_o).
//
// Optional feature: define DIV_ZERO_FAST_EN to finish a zero-divisor
// divide in one cycle without starting the divider.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   op_valid_i      E-stage instruction is DIV/DIVU
//   op_signed_i     1 = DIV, 0 = DIVU
//   opa_i, opb_i    dividend, divisor
//   flush_i         E-stage flush, annuls an in-flight divide
//   div_ready_i     divider result valid
//   div_result_i    divider result {remainder, quotient}
//   div_start_o     divider start, held while BUSY
//   div_signed_o    latched signedness
//   div_opa_o/opb_o latched operands
//   div_annul_o     divider abort pulse
//   stall_o         hold F/D/E pipeline registers
//   hilo_we_o       HI/LO write strobe
//   hilo_wdata_o    {HI, LO} write data
//   busy_o          controller not idle
//   err_o           sticky divider timeout flag
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic        op_signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opa_o,
  output logic [31:0] div_opb_o,
  output logic        div_annul_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_wdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          stateNext;
  logic [CntW-1:0] waitCnt;
  logic            accept;
  logic            zeroFast;
  logic            busyFlush;
  logic            busyDone;
  logic            timeout;

  // Decode the events that move the FSM. Flush dominates everything in
  // BUSY, and a ready arriving on the last allowed cycle still completes.
  always_comb begin
    accept    = (state == IDLE) && op_valid_i && !flush_i;
`ifdef DIV_ZERO_FAST_EN
    zeroFast  = accept && (opb_i == 32'd0);
`else
    zeroFast  = 1'b0;
`endif
    busyFlush = (state == BUSY) && flush_i;
    busyDone  = (state == BUSY) && !flush_i && div_ready_i;
    timeout   = (state == BUSY) && !flush_i && !div_ready_i && (waitCnt == CntLast);
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = zeroFast ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (busyFlush || timeout) begin
          stateNext = IDLE;
        end else if (busyDone) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are gated by reset so nothing (in particular no annul) is
  // signalled while rst is low; the divider resets itself from rst.
  // A flushed divide releases the stall in the same cycle since the
  // instruction it was holding is being killed anyway.
  always_comb begin
    div_start_o = rst && (state == BUSY);
    div_annul_o = rst && (busyFlush || timeout);
    stall_o     = rst && (accept || ((state == BUSY) && !flush_i));
    hilo_we_o   = rst && (state == DONE);
    busy_o      = rst && (state != IDLE);
  end

  // State, operand latches, wait counter, result and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      waitCnt      <= '0;
      div_opa_o    <= '0;
      div_opb_o    <= '0;
      div_signed_o <= 1'b0;
      hilo_wdata_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        div_opa_o    <= opa_i;
        div_opb_o    <= opb_i;
        div_signed_o <= op_signed_i;
      end
      if (accept) begin
        waitCnt <= '0;
      end else if (state == BUSY) begin
        waitCnt <= waitCnt + CntW'(1);
      end
      if (zeroFast) begin
        hilo_wdata_o <= {opa_i, DIV_ZERO_LO};
      end else if (busyDone) begin
        hilo_wdata_o <= div_result_i;
      end
      if (timeout) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl
// Directed testbench for div_ctrl. The divider is played by the bench:
// div_ready_i is raised in a chosen BUSY cycle together with a
// hand-computed {remainder, quotient}. Every divide is walked cycle by
// cycle and its stall/start/write/annul counts are compared with
// hand-derived values.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        opValid;
  logic        opSigned;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        divReady;
  logic [63:0] divResult;
  logic        divStart;
  logic        divSigned;
  logic [31:0] divOpa;
  logic [31:0] divOpb;
  logic        divAnnul;
  logic        stall;
  logic        hiloWe;
  logic [63:0] hiloWdata;
  logic        busy;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;

  div_ctrl #(.TIMEOUT_CYC(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid_i   (opValid),
    .op_signed_i  (opSigned),
    .opa_i        (opa),
    .opb_i        (opb),
    .flush_i      (flush),
    .div_ready_i  (divReady),
    .div_result_i (divResult),
    .div_start_o  (divStart),
    .div_signed_o (divSigned),
    .div_opa_o    (divOpa),
    .div_opb_o    (divOpb),
    .div_annul_o  (divAnnul),
    .stall_o      (stall),
    .hilo_we_o    (hiloWe),
    .hilo_wdata_o (hiloWdata),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic valid, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic fl, input logic rdy,
                               input logic [63:0] res);
    opValid   = valid;
    opSigned  = sgn;
    opa       = a;
    opb       = b;
    flush     = fl;
    divReady  = rdy;
    divResult = res;
  endtask

  // Run one divide starting from IDLE. op_valid_i is held high during the
  // whole operation (as a stalled pipeline would), div_ready_i is raised
  // in cycle readyAt and flush_i in cycle flushAt (cycle 0 = acceptance,
  // -1 = never). Returns at the cycle after the write or the annul.
  task automatic runDivide(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input int readyAt, input int flushAt,
                           input logic [63:0] res,
                           input int expStall, input int expStart,
                           input int expWe, input int expAnnul,
                           input logic [63:0] expWdata);
    int          stallCnt  = 0;
    int          startCnt  = 0;
    int          weCnt     = 0;
    int          annulCnt  = 0;
    int          weCycle   = -1;
    int          badOps    = 0;
    logic [63:0] seenWdata = '0;
    logic        busyAtOne = 1'b0;
    bit          finished  = 1'b0;
    for (int k = 0; k < 200 && !finished; k++) begin
      applyStimulus(1'b1, sgn, a, b, (k == flushAt), (k == readyAt), res);
      #4;
      if (stall)    stallCnt++;
      if (divAnnul) annulCnt++;
      if (k == 1)   busyAtOne = busy;
      if (divStart) begin
        startCnt++;
        if (divOpa !== a || divOpb !== b || divSigned !== sgn) badOps++;
      end
      if (hiloWe) begin
        weCnt++;
        weCycle   = k;
        seenWdata = hiloWdata;
      end
      if (hiloWe || divAnnul) finished = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, ".finished"}, 64'(finished), 64'd1);
    checkOutput({tag, ".accepted"}, 64'(busyAtOne), 64'd1);
    checkOutput({tag, ".stallCycles"}, 64'(stallCnt), 64'(expStall));
    checkOutput({tag, ".startCycles"}, 64'(startCnt), 64'(expStart));
    checkOutput({tag, ".writes"}, 64'(weCnt), 64'(expWe));
    checkOutput({tag, ".annuls"}, 64'(annulCnt), 64'(expAnnul));
    checkOutput({tag, ".operandsStable"}, 64'(badOps), 64'd0);
    if (expWe != 0) begin
      checkOutput({tag, ".wdata"}, seenWdata, expWdata);
      checkOutput({tag, ".weCycle"}, 64'(weCycle), 64'(expStall));
    end
    checkOutput({tag, ".idleAfter"}, 64'(busy), 64'd0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h9, 1'b0, 1'b0, 64'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: everything zero even with a divide being offered
    checkOutput("reset.stall", 64'(stall), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.start", 64'(divStart), 64'd0);
    checkOutput("reset.err", 64'(err), 64'd0);
    checkOutput("reset.wdata", hiloWdata, 64'd0);
    checkOutput("reset.opa", 64'(divOpa), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // DIV 100/7, ready in the 32nd BUSY cycle: 33 stall cycles, {2, 14}
    runDivide("div100by7", 1'b1, 32'd100, 32'd7, 32, -1, {32'd2, 32'd14},
              33, 32, 1, 0, {32'd2, 32'd14});
    // DIV -7/2 -> rem -1, quo -3
    runDivide("divNeg7by2", 1'b1, 32'hFFFF_FFF9, 32'd2, 5, -1,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 6, 5, 1, 0,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // DIVU 0xFFFFFFFF/2 -> rem 1, quo 0x7FFFFFFF (back-to-back with previous)
    runDivide("divuMaxBy2", 1'b0, 32'hFFFF_FFFF, 32'd2, 3, -1,
              {32'd1, 32'h7FFF_FFFF}, 4, 3, 1, 0, {32'd1, 32'h7FFF_FFFF});

    // Flush in IDLE blocks acceptance
    applyStimulus(1'b1, 1'b1, 32'd9, 32'd3, 1'b1, 1'b0, 64'h0);
    #4;
    checkOutput("idleFlush.stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("idleFlush.busy", 64'(busy), 64'd0);

    // Flush in BUSY cycle 10: annul, no write, stall low from that cycle
    runDivide("flushBusy", 1'b1, 32'd50, 32'd5, 32, 10, {32'd0, 32'd10},
              10, 10, 0, 1, 64'h0);
    // Flush coinciding with ready: flush wins
    runDivide("flushOnReady", 1'b0, 32'd50, 32'd5, 5, 5, {32'd0, 32'd10},
              5, 5, 0, 1, 64'h0);
    // Flush in DONE does not cancel the write
    runDivide("flushInDone", 1'b0, 32'd77, 32'd10, 4, 5, {32'd7, 32'd7},
              5, 4, 1, 0, {32'd7, 32'd7});
    checkOutput("preTimeout.err", 64'(err), 64'd0);

    // Divider never ready: abort in the 48th BUSY cycle
    runDivide("timeout", 1'b1, 32'd1, 32'd1, -1, -1, 64'h0,
              49, 48, 0, 1, 64'h0);
    checkOutput("timeout.err", 64'(err), 64'd1);
    runDivide("afterTimeout", 1'b0, 32'd20, 32'd6, 2, -1, {32'd2, 32'd3},
              3, 2, 1, 0, {32'd2, 32'd3});
    checkOutput("afterTimeout.errSticky", 64'(err), 64'd1);

    // Zero divisor
`ifdef DIV_ZERO_FAST_EN
    runDivide("zeroDiv", 1'b0, 32'd5, 32'd0, 3, -1, 64'h0,
              1, 0, 1, 0, {32'd5, 32'hFFFF_FFFF});
`else
    runDivide("zeroDiv", 1'b0, 32'd5, 32'd0, 3, -1, {32'd5, 32'hFFFF_FFFF},
              4, 3, 1, 0, {32'd5, 32'hFFFF_FFFF});
`endif

    // Reset while BUSY (with flush asserted) must not annul, and clears err
    applyStimulus(1'b1, 1'b1, 32'd40, 32'd8, 1'b0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 32'd40, 32'd8, 1'b1, 1'b0, 64'h0);
    rst = 1'b0;
    #4;
    checkOutput("resetBusy.annul", 64'(divAnnul), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("resetBusy.busy", 64'(busy), 64'd0);
    checkOutput("resetBusy.err", 64'(err), 64'd0);
    checkOutput("resetBusy.wdata", hiloWdata, 64'd0);
    checkOutput("resetBusy.opb", 64'(divOpb), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
